// File: rtl/load_store_unit_if.sv
// Request, memory and writeback bundle between the pipeline, the load/store unit and data memory.
// The slave modport is the unit's view; master is the view of whatever drives requests and models memory.
interface load_store_unit_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              mem_we;

    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              misalign;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rd, mem_rdata,
        output req_ready, mem_addr, mem_waddr, mem_wdata, mem_we,
               wb_valid, wb_rd, wb_data, misalign
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rd, mem_rdata,
        input  req_ready, mem_addr, mem_waddr, mem_wdata, mem_we,
               wb_valid, wb_rd, wb_data, misalign
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-request load/store unit over a word-wide memory with combinational read.
// Sub-word stores are done as read-modify-write; loads are extended and registered for writeback.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, READ, WRITE, RMW_READ, RMW_WRITE, ERR
    } state_t;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000, OP_LH = 3'b001, OP_LHU = 3'b010, OP_LB = 3'b011,
        OP_LBU = 3'b100, OP_SW = 3'b101, OP_SH  = 3'b110, OP_SB = 3'b111
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [4:0]        rd_q;
    logic [31:0]       merged_q;

    logic              req_fire;
    logic              req_misaligned;
    op_t               req_op;
    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        lane;
    logic              unused_addr_hi;

    // Address bits above the memory's word range alias; they never affect the access.
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    assign req_op    = op_t'(bus.req_op);
    assign req_fire  = (state_q == IDLE) && bus.req_valid;
    assign word_addr = addr_q[ADDR_W+1:2];
    assign lane      = addr_q[1:0];

    function automatic logic [31:0] extend_load(op_t op, logic [1:0] ln, logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ln, 3'b000} +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0000, h};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h000000, b};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(op_t op, logic [1:0] ln,
                                                logic [31:0] word, logic [31:0] wdata);
        logic [31:0] m;
        m = word;
        if (op == OP_SH) begin
            if (ln[1]) m[31:16] = wdata[15:0];
            else       m[15:0]  = wdata[15:0];
        end else begin
            m[{ln, 3'b000} +: 8] = wdata[7:0];
        end
        return m;
    endfunction

    always_comb begin
        req_misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:         req_misaligned = (bus.req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: req_misaligned = bus.req_addr[0];
            default:              req_misaligned = 1'b0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_misaligned)     state_d = ERR;
                    else if (req_op <= OP_LBU) state_d = READ;
                    else if (req_op == OP_SW)  state_d = WRITE;
                    else                       state_d = RMW_READ;
                end
            end
            RMW_READ: state_d = RMW_WRITE;
            default:  state_d = IDLE;
        endcase
    end

    // Memory-side outputs decode from state alone, so reset clears them without a clock.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.mem_we    = (state_q == WRITE) || (state_q == RMW_WRITE);
        bus.misalign  = (state_q == ERR);
        bus.mem_addr  = (state_q == IDLE) ? '0 : word_addr;
        bus.mem_waddr = (state_q == IDLE) ? '0 : word_addr;
        case (state_q)
            WRITE:     bus.mem_wdata = wdata_q;
            RMW_WRITE: bus.mem_wdata = merged_q;
            default:   bus.mem_wdata = 32'h0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_LW;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rd_q     <= 5'd0;
            merged_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                op_q    <= req_op;
                addr_q  <= bus.req_addr[ADDR_W+1:0];
                wdata_q <= bus.req_wdata;
                rd_q    <= bus.req_rd;
            end
            if (state_q == RMW_READ)
                merged_q <= merge_store(op_q, lane, bus.mem_rdata, wdata_q);
        end
    end

    // Writeback is registered out of READ, giving a two-cycle load latency from acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_valid <= 1'b0;
            bus.wb_rd    <= 5'd0;
            bus.wb_data  <= 32'h0;
        end else begin
            bus.wb_valid <= (state_q == READ) && (rd_q != 5'd0);
            if (state_q == READ) begin
                bus.wb_rd   <= rd_q;
                bus.wb_data <= extend_load(op_q, lane, bus.mem_rdata);
            end
        end
    end

endmodule
